tinyalu_cmd_sequencer: RTL and testbench

//  Synthesisable, parametrised successor to the op/result FIFO pairing around the TinyALU.

---
 rtl/tinyalu_rtl_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 63 ++++++
 rtl/tinyalu_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tinyalu_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_rtl_pkg.sv
// rtl/tinyalu_rtl_pkg.sv - TinyALU opcode enum, command struct and opcode helper
package tinyalu_rtl_pkg;

  localparam int ALU_OP_W      = 3;
  localparam int ALU_DEF_WIDTH = 8;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [ALU_DEF_WIDTH-1:0] a;
    logic [ALU_DEF_WIDTH-1:0] b;
    logic [ALU_OP_W-1:0]      op;
  } alu_cmd_t;

  // NO_OP and the undefined codes 5-7 never reach the core
  function automatic logic is_issuable_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_AND) || (op == ALU_XOR) || (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with full/empty/count, no write-through
module alu_cmd_fifo
  import tinyalu_rtl_pkg::*;
#(
  parameter type T     = alu_cmd_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full blocks a push even when a pop happens on the same edge
  assign w_push  = wr_valid && !full;
  assign w_pop   = rd_en && !empty;
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// rtl/tinyalu_cmd_sequencer.sv - queues ALU commands, drives a start/done core, holds results
// Optional BUSY watchdog enabled by defining TINYALU_WATCHDOG_EN.
module tinyalu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*WIDTH-1:0]         res_data,
  output logic [2:0]                 res_op,
  output logic                       res_err,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [2:0]                 alu_op,
  output logic                       alu_start,
  input  logic                       alu_done,
  input  logic [2*WIDTH-1:0]         alu_result,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  import tinyalu_rtl_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [ALU_OP_W-1:0] op;
  } cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_op;
  logic               r_alu_start;
  logic               r_res_valid;
  logic [2*WIDTH-1:0] r_res_data;
  logic [2:0]         r_res_op;

  cmd_t w_push_cmd;
  cmd_t w_head;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_pop;
  logic w_res_hs;
  logic w_wd_expire;

  assign w_push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty && !r_res_valid;
  assign w_res_hs   = r_res_valid && res_ready;
  assign cmd_ready  = !w_fifo_full;

  alu_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (cmd_valid),
    .wr_data  (w_push_cmd),
    .rd_en    (w_pop),
    .rd_data  (w_head),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .count    (fill_level)
  );

`ifdef TINYALU_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT+1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_res_err;

  assign w_wd_expire = (r_state == ST_BUSY) && (r_wd_cnt == WD_W'(TIMEOUT-1));
  assign res_err     = r_res_err;

  // Counts BUSY cycles; idles at zero so each issue starts a fresh window
  always_ff @(posedge clk) begin
    if (reset || r_state != ST_BUSY || alu_done || w_wd_expire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_err <= 1'b0;
    end else if (w_wd_expire && !alu_done) begin
      r_res_err <= 1'b1;
    end else if (w_res_hs) begin
      r_res_err <= 1'b0;
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_wd_expire      = 1'b0;
  assign res_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
    end else begin
      if (w_res_hs) begin
        r_res_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          // Illegal/no-op entries are popped and dropped without touching the core
          if (w_pop && is_issuable_op(w_head.op)) begin
            r_alu_a     <= w_head.a;
            r_alu_b     <= w_head.b;
            r_alu_op    <= w_head.op;
            r_alu_start <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (alu_done) begin
            r_res_data  <= alu_result;
            r_res_op    <= r_alu_op;
            r_res_valid <= 1'b1;
            r_alu_start <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_wd_expire) begin
            r_res_data  <= '0;
            r_res_op    <= r_alu_op;
            r_res_valid <= 1'b1;
            r_alu_start <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_start = r_alu_start;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;

endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// tb/tb_tinyalu_cmd_sequencer.sv - directed self-checking bench for tinyalu_cmd_sequencer
module tb_tinyalu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        res_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [2:0]  fill_level;

  int n_total = 0;
  int n_bad   = 0;

  tinyalu_cmd_sequencer #(
    .WIDTH   (8),
    .DEPTH   (4),
    .TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .res_err    (res_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference TinyALU core behaviour
  function automatic logic [15:0] core_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [2:0] eop, input logic [15:0] eres);
    int waited = 0;
    while (alu_start !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_start"}, 32'(alu_start), 32'd1);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(eop));
    alu_result = core_calc(alu_a, alu_b, alu_op);
    alu_done   = 1'b1;
    tick();
    alu_done   = 1'b0;
    alu_result = '0;
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_res_data"}, 32'(res_data), 32'(eres));
    check({tag, "_res_op"}, 32'(res_op), 32'(eop));
    check({tag, "_start_drop"}, 32'(alu_start), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_res_consumed"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    res_ready  = 1'b0;
    alu_done   = 1'b0;
    alu_result = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);

    // add FF+01, core answers three cycles after issue
    push(8'hFF, 8'h01, 3'd1);
    check("t1_fill_after_push", 32'(fill_level), 32'd1);
    check("t1_start_not_yet", 32'(alu_start), 32'd0);
    tick();
    check("t1_start", 32'(alu_start), 32'd1);
    check("t1_alu_a", 32'(alu_a), 32'h0FF);
    check("t1_alu_b", 32'(alu_b), 32'h001);
    check("t1_alu_op", 32'(alu_op), 32'd1);
    check("t1_fill_after_pop", 32'(fill_level), 32'd0);
    tick();
    tick();
    check("t1_start_held", 32'(alu_start), 32'd1);
    alu_result = core_calc(alu_a, alu_b, alu_op);
    alu_done   = 1'b1;
    tick();
    alu_done   = 1'b0;
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data", 32'(res_data), 32'h0100);
    check("t1_res_op", 32'(res_op), 32'd1);
    check("t1_start_drop", 32'(alu_start), 32'd0);
    repeat (5) tick();
    check("t1_res_hold", 32'(res_valid), 32'd1);

    // Result pending: fill the queue, 5th command must wait for the first pop
    push(8'h12, 8'h34, 3'd1);
    push(8'hF0, 8'h3C, 3'd2);
    push(8'hAA, 8'h55, 3'd3);
    push(8'h03, 8'h05, 3'd4);
    check("t2_fill_full", 32'(fill_level), 32'd4);
    check("t2_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_a     = 8'h0F;
    cmd_b     = 8'h11;
    cmd_op    = 3'd4;
    repeat (10) tick();
    check("t4_no_issue", 32'(alu_start), 32'd0);
    check("t4_res_data_stable", 32'(res_data), 32'h0100);
    check("t4_res_valid_held", 32'(res_valid), 32'd1);
    check("t2_fill_still_full", 32'(fill_level), 32'd4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t2_hs_res_valid", 32'(res_valid), 32'd0);
    check("t2_hs_fill", 32'(fill_level), 32'd4);
    tick();
    check("t2_pop_fill", 32'(fill_level), 32'd3);
    check("t2_pop_start", 32'(alu_start), 32'd1);
    check("t2_pop_alu_a", 32'(alu_a), 32'h012);
    check("t2_ready_back", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("t2_fifth_in", 32'(fill_level), 32'd4);
    run_one("q_add", 3'd1, 16'h0046);
    run_one("q_and", 3'd2, 16'h0030);
    run_one("q_xor", 3'd3, 16'h00FF);
    run_one("q_mul", 3'd4, 16'h000F);
    run_one("q_mul2", 3'd4, 16'h00FF);
    check("t2_drained", 32'(fill_level), 32'd0);

    // no_op and illegal op are dropped; only the mul produces a result
    push(8'h00, 8'h00, 3'd0);
    push(8'h11, 8'h22, 3'd6);
    push(8'h0A, 8'h0B, 3'd4);
    check("t3_skip_no_start", 32'(alu_start), 32'd0);
    check("t3_skip_fill", 32'(fill_level), 32'd1);
    run_one("t3_mul", 3'd4, 16'h006E);
    repeat (3) tick();
    check("t3_single_result", 32'(res_valid), 32'd0);
    check("t3_fill_empty", 32'(fill_level), 32'd0);

    // Reset while busy discards the in-flight op and queue; late done ignored
    push(8'h01, 8'h02, 3'd1);
    push(8'h03, 8'h04, 3'd3);
    check("t5_busy", 32'(alu_start), 32'd1);
    check("t5_fill_before", 32'(fill_level), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_start_drop", 32'(alu_start), 32'd0);
    check("t5_fill_cleared", 32'(fill_level), 32'd0);
    check("t5_res_valid", 32'(res_valid), 32'd0);
    reset      = 1'b0;
    alu_result = 16'h0003;
    alu_done   = 1'b1;
    tick();
    alu_done   = 1'b0;
    alu_result = '0;
    check("t5_late_done_res", 32'(res_valid), 32'd0);
    check("t5_late_done_start", 32'(alu_start), 32'd0);

`ifdef TINYALU_WATCHDOG_EN
    // No alu_done: timeout after 64 BUSY cycles
    push(8'h55, 8'h66, 3'd1);
    tick();
    check("t6_start", 32'(alu_start), 32'd1);
    repeat (63) tick();
    check("t6_not_yet", 32'(res_valid), 32'd0);
    check("t6_still_busy", 32'(alu_start), 32'd1);
    tick();
    check("t6_res_valid", 32'(res_valid), 32'd1);
    check("t6_res_err", 32'(res_err), 32'd1);
    check("t6_res_data", 32'(res_data), 32'd0);
    check("t6_res_op", 32'(res_op), 32'd1);
    check("t6_start_drop", 32'(alu_start), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t6_err_clear", 32'(res_err), 32'd0);
    check("t6_res_consumed", 32'(res_valid), 32'd0);
`else
    // Without the watchdog BUSY waits indefinitely
    push(8'h55, 8'h66, 3'd1);
    tick();
    repeat (80) tick();
    check("t6_wait_busy", 32'(alu_start), 32'd1);
    check("t6_wait_no_res", 32'(res_valid), 32'd0);
    check("t6_err_tied", 32'(res_err), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
